// File: rtl/rover_motor_drive_pkg.sv
// Motion-command interface shared with the mic-localization block:
// FSM state encoding, command bit positions and the wheel pattern map.
package rover_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        RAMP = 2'd2,
        RUN  = 2'd3
    } state_e;

    localparam int unsigned CMD_W    = 3;
    localparam int unsigned CMD_DIR  = 0;
    localparam int unsigned CMD_ROT  = 1;
    localparam int unsigned CMD_MOVE = 2;

    // Returns {left_dir, right_dir}; 1 = forward.
    function automatic logic [1:0] wheel_dirs(input logic [CMD_W-1:0] cmd);
        logic l;
        logic r;
        l = cmd[CMD_DIR];
        r = cmd[CMD_ROT] ? ~cmd[CMD_DIR] : cmd[CMD_DIR];
        return {l, r};
    endfunction

endpackage

// File: rtl/rover_motor_drive_cmd_filter.sv
// Stability filter: a raw command is accepted only after holding for
// STABLE_CYCLES consecutive cycles; cmd_changed_o pulses with each new accept.
module rover_cmd_filter
    import rover_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CMD_W-1:0] raw_i,
    output logic [CMD_W-1:0] cmd_o,
    output logic             cmd_changed_o
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(STABLE_CYCLES);

    logic [CMD_W-1:0] last_q, last_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             chg_q, chg_d;

    // The cycle on which raw changes already counts as the first held cycle.
    always_comb begin
        last_d = raw_i;
        cnt_d  = cnt_q;
        cmd_d  = cmd_q;
        chg_d  = 1'b0;
        if (raw_i != last_q)
            cnt_d = CW'(1);
        else if (cnt_q != HOLD_MAX)
            cnt_d = cnt_q + 1'b1;
        if (cnt_d == HOLD_MAX && raw_i != cmd_q) begin
            cmd_d = raw_i;
            chg_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= '0;
            cmd_q  <= '0;
            cnt_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            cmd_q  <= cmd_d;
            cnt_q  <= cnt_d;
            chg_q  <= chg_d;
        end
    end

    assign cmd_o         = cmd_q;
    assign cmd_changed_o = chg_q;

endmodule

// File: rtl/rover_motor_drive.sv
// H-bridge drive for the rover: filtered motion command -> wheel directions,
// soft-started shared PWM duty, and a PWM-off dead time on every pattern change.
module rover_motor_drive
    import rover_pkg::*;
#(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned FWD_DUTY      = 200,
    parameter int unsigned ROT_DUTY      = 150,
    parameter int unsigned RAMP_DIV      = 50000,
    parameter int unsigned DEAD_CYCLES   = 100000,
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Direction,
    input  logic Rotate,
    input  logic Move,
    output logic left_pwm,
    output logic left_dir,
    output logic right_pwm,
    output logic right_dir,
    output logic moving
);

    if (FWD_DUTY >= (2 ** PWM_BITS) || ROT_DUTY >= (2 ** PWM_BITS) ||
        RAMP_DIV < 1 || DEAD_CYCLES < 1 || STABLE_CYCLES < 1) begin : g_param_check
        $error("rover_motor_drive: duty targets must be < 2**PWM_BITS, timers >= 1");
    end

    localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] FWD_T     = PWM_BITS'(FWD_DUTY);
    localparam logic [PWM_BITS-1:0] ROT_T     = PWM_BITS'(ROT_DUTY);

    logic [CMD_W-1:0]    cmd;
    logic                cmd_chg;
    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic [RW-1:0]       ramp_q, ramp_d;
    logic [1:0]          dirs_q, dirs_d;
    logic [PWM_BITS-1:0] cnt_q;
    logic                pwm_q, pwm_d;
    logic [PWM_BITS-1:0] target;

    rover_cmd_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .raw_i        ({Move, Rotate, Direction}),
        .cmd_o        (cmd),
        .cmd_changed_o(cmd_chg)
    );

    assign target = cmd[CMD_ROT] ? ROT_T : FWD_T;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dead_d  = dead_q;
        ramp_d  = ramp_q;
        dirs_d  = dirs_q;
        if (!cmd[CMD_MOVE]) begin
            state_d = IDLE;
            duty_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = DEAD;
                    dead_d  = '0;
                    duty_d  = '0;
                end
                DEAD: begin
                    duty_d = '0;
                    if (cmd_chg)
                        dead_d = '0;
                    else if (dead_q == DEAD_LAST) begin
                        state_d = RAMP;
                        ramp_d  = '0;
                        dirs_d  = wheel_dirs(cmd);
                    end else
                        dead_d = dead_q + 1'b1;
                end
                RAMP: begin
                    if (cmd_chg) begin
                        state_d = DEAD;
                        dead_d  = '0;
                        duty_d  = '0;
                    end else if (duty_q == target)
                        state_d = RUN;
                    else if (ramp_q == RAMP_LAST) begin
                        ramp_d = '0;
                        duty_d = duty_q + 1'b1;
                    end else
                        ramp_d = ramp_q + 1'b1;
                end
                RUN: begin
                    if (cmd_chg) begin
                        state_d = DEAD;
                        dead_d  = '0;
                        duty_d  = '0;
                    end else
                        duty_d = target;
                end
                default: state_d = IDLE;
            endcase
        end
        // Gate with the next state so pwm drops on the same edge motion stops.
        pwm_d = ((state_d == RAMP) || (state_d == RUN)) && (cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            dead_q  <= '0;
            ramp_q  <= '0;
            dirs_q  <= '0;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            ramp_q  <= ramp_d;
            dirs_q  <= dirs_d;
            cnt_q   <= cnt_q + 1'b1;
            pwm_q   <= pwm_d;
        end
    end

    assign left_pwm  = pwm_q;
    assign right_pwm = pwm_q;
    assign left_dir  = dirs_q[1];
    assign right_dir = dirs_q[0];
    assign moving    = (state_q == RAMP) || (state_q == RUN);

endmodule

// File: tb/tb_rover_motor_drive.sv
// Bench for rover_motor_drive: directed scenarios plus random command streams,
// checked every cycle against an elapsed-time reference model.
module tb_rover_motor_drive;

    localparam int PB = 4, FWD = 12, ROT = 8, RDIV = 2, DEADC = 5, STAB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Direction = 1'b0, Rotate = 1'b0, Move = 1'b0;
    logic left_pwm, left_dir, right_pwm, right_dir, moving;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 = stopped, 1 = dead time, 2 = driving.
    logic [2:0] m_last, m_acc;
    int m_hold, m_chg, m_mode, m_t, m_duty, m_ldir, m_rdir, m_cnt, m_pwm;

    always #5 clk = ~clk;

    rover_motor_drive #(
        .PWM_BITS(PB), .FWD_DUTY(FWD), .ROT_DUTY(ROT),
        .RAMP_DIV(RDIV), .DEAD_CYCLES(DEADC), .STABLE_CYCLES(STAB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Direction(Direction), .Rotate(Rotate), .Move(Move),
        .left_pwm(left_pwm), .left_dir(left_dir), .right_pwm(right_pwm),
        .right_dir(right_dir), .moving(moving)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [2:0] raw, input logic r);
        logic [2:0] o_acc;
        int o_chg, o_cnt, o_duty, tgt, ramped;
        if (!r) begin
            m_last = '0; m_acc = '0; m_hold = 0; m_chg = 0; m_mode = 0; m_t = 0;
            m_duty = 0; m_ldir = 0; m_rdir = 0; m_cnt = 0; m_pwm = 0;
            return;
        end
        o_acc = m_acc; o_chg = m_chg; o_cnt = m_cnt; o_duty = m_duty;
        if (raw != m_last) begin m_last = raw; m_hold = 1; end
        else if (m_hold < STAB) m_hold++;
        m_chg = 0;
        if (m_hold == STAB && raw != m_acc) begin m_acc = raw; m_chg = 1; end
        if (!o_acc[2]) m_mode = 0;
        else case (m_mode)
            0: begin m_mode = 1; m_t = 0; end
            1: if (o_chg != 0) m_t = 0;
               else if (m_t == DEADC - 1) begin
                   m_mode = 2; m_t = 0;
                   case (o_acc[1:0])
                       2'b01: begin m_ldir = 1; m_rdir = 1; end
                       2'b00: begin m_ldir = 0; m_rdir = 0; end
                       2'b11: begin m_ldir = 1; m_rdir = 0; end
                       default: begin m_ldir = 0; m_rdir = 1; end
                   endcase
               end else m_t++;
            default: if (o_chg != 0) begin m_mode = 1; m_t = 0; end else m_t++;
        endcase
        tgt = o_acc[1] ? ROT : FWD;
        ramped = m_t / RDIV;
        m_duty = (m_mode == 2) ? ((ramped < tgt) ? ramped : tgt) : 0;
        m_pwm = (m_mode == 2 && o_cnt < o_duty) ? 1 : 0;
        m_cnt = (o_cnt + 1) % (1 << PB);
    endtask

    task automatic tick();
        logic [2:0] raw;
        logic r, p_ld, p_rd, p_pwm;
        raw = {Move, Rotate, Direction};
        r = rst_n;
        p_ld = left_dir; p_rd = right_dir; p_pwm = left_pwm | right_pwm;
        @(posedge clk);
        model_update(raw, r);
        #1;
        chk("left_pwm", left_pwm, m_pwm);
        chk("right_pwm", right_pwm, m_pwm);
        chk("left_dir", left_dir, m_ldir);
        chk("right_dir", right_dir, m_rdir);
        chk("moving", moving, (m_mode == 2) ? 1 : 0);
        if (r && (left_dir !== p_ld || right_dir !== p_rd))
            chk("dir_change_pwm_off", {p_pwm, left_pwm | right_pwm}, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cmd(input logic mv, input logic rot, input logic dir);
        Move = mv; Rotate = rot; Direction = dir;
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            c += int'(left_pwm);
        end
    endtask

    initial begin
        int c;
        // Reset
        rst_n = 1'b0;
        ticks(2);
        chk("reset_outputs", {left_pwm, left_dir, right_pwm, right_dir, moving}, 0);
        rst_n = 1'b1;

        // 1: forward, dead time, ramp to 12, 12/16 duty in RUN
        set_cmd(1, 0, 1);
        ticks(4);
        for (int i = 0; i < DEADC; i++) begin
            chk("t1_dead_pwm", left_pwm | right_pwm, 0);
            tick();
        end
        chk("t1_dirs", {left_dir, right_dir}, 2'b11);
        chk("t1_moving", moving, 1);
        ticks(FWD * RDIV + 4);
        count_high(16, c);
        chk("t1_run_duty", c, FWD);

        // 2: short Move glitch ignored
        set_cmd(0, 0, 1);
        ticks(2);
        set_cmd(1, 0, 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t2_glitch_moving", moving, 1);
        end

        // 3: rotate left from RUN
        set_cmd(1, 1, 0);
        ticks(4);
        for (int i = 0; i < DEADC; i++) begin
            chk("t3_dead_pwm", left_pwm | right_pwm, 0);
            tick();
        end
        chk("t3_dirs", {left_dir, right_dir}, 2'b01);
        ticks(ROT * RDIV + 4);
        count_high(16, c);
        chk("t3_run_duty", c, ROT);

        // 4: drop Move mid-ramp
        set_cmd(1, 0, 1);
        ticks(4 + DEADC + 6);
        chk("t4_ramping", moving, 1);
        set_cmd(0, 0, 1);
        ticks(STAB + 1);
        chk("t4_stopped", {moving, left_pwm, right_pwm}, 0);
        chk("t4_dirs_kept", {left_dir, right_dir}, 2'b11);

        // 5: toggle Direction right at dead-time entry -> count restarts
        set_cmd(1, 0, 1);
        ticks(STAB + 1);
        set_cmd(1, 0, 0);
        ticks(STAB + 1);
        for (int i = 0; i < DEADC - 1; i++) begin
            tick();
            chk("t5_dead_restart", moving, 0);
        end
        tick();
        chk("t5_ramp_entry", moving, 1);
        chk("t5_dirs", {left_dir, right_dir}, 2'b00);

        // 6: reset during RUN, command held through it
        set_cmd(1, 0, 1);
        ticks(STAB + 1 + DEADC + FWD * RDIV + 8);
        chk("t6_running", moving, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_reset_outputs", {left_pwm, left_dir, right_pwm, right_dir, moving}, 0);
        rst_n = 1'b1;
        ticks(STAB + 1 + DEADC - 1);
        chk("t6_still_dead", moving, 0);
        tick();
        chk("t6_reaccepted", moving, 1);

        // Random command streams with occasional resets
        for (int s = 0; s < 250; s++) begin
            logic [2:0] r3;
            r3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) r3[2] = 1'b1;
            set_cmd(r3[2], r3[1], r3[0]);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            ticks(($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 60))
                                               : int'($urandom_range(1, 10)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
